// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 timing constants, counter width and pipeline flag bundle
package vga_timing_pkg;
  localparam int CW         = 10;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic first;
  } flags_t;
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel coordinate request and colour return between timing block and colour source
interface vga_timing_if import vga_timing_pkg::*;;
  logic [CW-1:0] x_o;
  logic [CW-1:0] y_o;
  logic          req_o;
  logic [3:0]    red_i;
  logic [3:0]    green_i;
  logic [3:0]    blue_i;
  modport master (output x_o, y_o, req_o, input red_i, green_i, blue_i);
  modport slave  (input x_o, y_o, req_o, output red_i, green_i, blue_i);
endinterface

// File: rtl/vga_timing_counter.sv
// vga_counter: modulo-N counter with enable, async active-low reset and terminal-count wrap flag
module vga_counter import vga_timing_pkg::*; #(
  parameter int N = H_TOTAL_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap
);
  localparam logic [CW-1:0] MAX = CW'(N - 1);
  assign wrap = cnt == MAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: pixel divider, h/v counters and two-stage sync/colour alignment to the connector
module vga_timing import vga_timing_pkg::*; #(
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 1
) (
  input  logic               ice_clk_i,
  input  logic               rst_n_i,
  vga_timing_if.master       src,
  output logic               hs_o,
  output logic               vs_o,
  output logic [3:0]         red_o,
  output logic [3:0]         green_o,
  output logic [3:0]         blue_o,
  output logic               de_o,
  output logic               frame_o
);
  localparam int            H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int            V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [15:0]   DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic [15:0]   div;
  logic          pix_en;
  logic          h_wrap;
  logic          v_wrap_unused;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  flags_t        s0;
  flags_t        s1;
  assign pix_en = div == DIV_MAX;
  always_ff @(posedge ice_clk_i or negedge rst_n_i)
    if (!rst_n_i) div <= '0;
    else div <= pix_en ? '0 : div + 1'b1;
  vga_counter #(.N(H_TOTAL)) u_h (
    .clk(ice_clk_i), .rst_n(rst_n_i), .en(pix_en), .cnt(hcnt), .wrap(h_wrap)
  );
  vga_counter #(.N(V_TOTAL)) u_v (
    .clk(ice_clk_i), .rst_n(rst_n_i), .en(pix_en & h_wrap), .cnt(vcnt), .wrap(v_wrap_unused)
  );
  assign src.x_o   = hcnt;
  assign src.y_o   = vcnt;
  assign src.req_o = hcnt < H_ACT && vcnt < V_ACT;
  always_comb begin
    s0.hs    = hcnt >= HS_BEG && hcnt < HS_END;
    s0.vs    = vcnt >= VS_BEG && vcnt < VS_END;
    s0.de    = src.req_o;
    s0.first = hcnt == '0 && vcnt == '0 && div == '0;
  end
  always_ff @(posedge ice_clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      s1      <= '0;
      hs_o    <= ~HS_POL;
      vs_o    <= ~VS_POL;
      de_o    <= 1'b0;
      frame_o <= 1'b0;
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
    end else begin
      s1      <= s0;
      hs_o    <= s1.hs ? HS_POL : ~HS_POL;
      vs_o    <= s1.vs ? VS_POL : ~VS_POL;
      de_o    <= s1.de;
      frame_o <= s1.first;
      red_o   <= s1.de ? src.red_i : '0;
      green_o <= s1.de ? src.green_i : '0;
      blue_o  <= s1.de ? src.blue_i : '0;
    end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of reset, sync timing, alignment, blanking, divider and mid-line reset
module tb_vga_timing;
  import vga_timing_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a_n, rst_b_n, rst_c_n, src_f;
  int cyc = 0, t0 = 0, chk = 0, pass = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic hs_a, vs_a, de_a, fr_a, hs_b, vs_b, de_b, fr_b, hs_c, vs_c, de_c, fr_c;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  vga_timing_if ifa ();
  vga_timing_if ifb ();
  vga_timing_if ifc ();
  always @(posedge clk) begin
    ifa.red_i   <= src_f ? 4'hF : ifa.x_o[3:0];
    ifa.green_i <= src_f ? 4'hF : ifa.y_o[3:0];
    ifa.blue_i  <= src_f ? 4'hF : ifa.x_o[7:4];
  end
  assign ifb.red_i = 4'h5;
  assign ifb.green_i = 4'h6;
  assign ifb.blue_i = 4'h7;
  assign ifc.red_i = 4'hA;
  assign ifc.green_i = 4'h5;
  assign ifc.blue_i = 4'h3;
  vga_timing u_a (
    .ice_clk_i(clk), .rst_n_i(rst_a_n), .src(ifa.master), .hs_o(hs_a), .vs_o(vs_a),
    .red_o(r_a), .green_o(g_a), .blue_o(b_a), .de_o(de_a), .frame_o(fr_a)
  );
  vga_timing #(.CLK_DIV(2)) u_b (
    .ice_clk_i(clk), .rst_n_i(rst_b_n), .src(ifb.master), .hs_o(hs_b), .vs_o(vs_b),
    .red_o(r_b), .green_o(g_b), .blue_o(b_b), .de_o(de_b), .frame_o(fr_b)
  );
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
  ) u_c (
    .ice_clk_i(clk), .rst_n_i(rst_c_n), .src(ifc.master), .hs_o(hs_c), .vs_o(vs_c),
    .red_o(r_c), .green_o(g_c), .blue_o(b_c), .de_o(de_c), .frame_o(fr_c)
  );
  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0; src_f = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk++; if ({hs_a, vs_a, de_a, fr_a} !== 4'b1100) $display("FAIL reset_a_flags got %b want 1100", {hs_a, vs_a, de_a, fr_a}); else pass++;
      chk++; if ({r_a, g_a, b_a} !== 12'h000) $display("FAIL reset_a_colour got %h want 000", {r_a, g_a, b_a}); else pass++;
      chk++; if ({ifa.x_o, ifa.y_o, ifa.req_o} !== {10'd0, 10'd0, 1'b1}) $display("FAIL reset_a_xy got %0d,%0d req %b want 0,0 req 1", ifa.x_o, ifa.y_o, ifa.req_o); else pass++;
      chk++; if ({hs_b, vs_b, de_b, fr_b, r_b, g_b, b_b} !== {4'b1100, 12'h000}) $display("FAIL reset_b got %b want 1100 and colour 0", {hs_b, vs_b, de_b, fr_b}); else pass++;
      chk++; if ({hs_c, vs_c, de_c, fr_c} !== 4'b0000) $display("FAIL reset_c_pol got %b want 0000", {hs_c, vs_c, de_c, fr_c}); else pass++;
    end
  endtask
  task automatic test_first_frame();
    rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1; t0 = cyc;
    @(negedge clk);
    chk++; if ({fr_a, de_a, fr_b, fr_c} !== 4'b0000) $display("FAIL first_t1_frame got %b want 0000", {fr_a, de_a, fr_b, fr_c}); else pass++;
    chk++; if ({ifa.x_o, ifb.x_o} !== {10'd1, 10'd0}) $display("FAIL first_t1_x got %0d,%0d want 1,0", ifa.x_o, ifb.x_o); else pass++;
    @(negedge clk);
    chk++; if ({fr_a, de_a, fr_b, de_b, fr_c, de_c} !== 6'b111111) $display("FAIL first_t2_frame got %b want 111111", {fr_a, de_a, fr_b, de_b, fr_c, de_c}); else pass++;
    chk++; if ({hs_a, vs_a} !== 2'b11) $display("FAIL first_t2_sync got %b want 11", {hs_a, vs_a}); else pass++;
    @(negedge clk);
    chk++; if ({fr_a, de_a, fr_b, de_b} !== 4'b0101) $display("FAIL first_t3_pulse got %b want 0101", {fr_a, de_a, fr_b, de_b}); else pass++;
    chk++; if (ifb.x_o !== 10'd1) $display("FAIL first_t3_xb got %0d want 1", ifb.x_o); else pass++;
  endtask
  task automatic test_horizontal();
    int f1 = -1, f2 = -1, r1 = -1, d1 = -1, dhi = 0, tt;
    logic ph = hs_a, pd = de_a;
    while (cyc - t0 < 1500) begin
      @(negedge clk);
      tt = cyc - t0;
      if (ph && !hs_a) begin
        if (f1 < 0) f1 = tt;
        else if (f2 < 0) f2 = tt;
      end
      if (!ph && hs_a && r1 < 0) r1 = tt;
      if (pd && !de_a && d1 < 0) d1 = tt;
      if (f1 >= 0 && f2 < 0 && de_a) dhi++;
      ph = hs_a;
      pd = de_a;
    end
    chk++; if (f1 !== 658) $display("FAIL h_first_fall got %0d want 658", f1); else pass++;
    chk++; if (r1 - f1 !== 96) $display("FAIL h_sync_width got %0d want 96", r1 - f1); else pass++;
    chk++; if (f2 - f1 !== 800) $display("FAIL h_period got %0d want 800", f2 - f1); else pass++;
    chk++; if (f1 - d1 !== 16) $display("FAIL h_de_to_hs got %0d want 16", f1 - d1); else pass++;
    chk++; if (dhi !== 640) $display("FAIL h_de_count got %0d want 640", dhi); else pass++;
  endtask
  task automatic test_alignment();
    logic [9:0] x, y, xc, yc;
    int p;
    src_f = 1'b0;
    while (cyc - t0 < 4100) begin
      @(negedge clk);
      p = cyc - t0 - 2;
      x = 10'(p % 800); y = 10'(p / 800);
      xc = 10'((p + 2) % 800); yc = 10'((p + 2) / 800);
      chk++; if (de_a !== (x < 640 && y < 480)) $display("FAIL align_de t=%0d got %b want %b", p + 2, de_a, x < 640 && y < 480); else pass++;
      if (x < 640) begin
        chk++; if ({r_a, g_a, b_a} !== {x[3:0], y[3:0], x[7:4]}) $display("FAIL align_rgb (%0d,%0d) got %h want %h", x, y, {r_a, g_a, b_a}, {x[3:0], y[3:0], x[7:4]}); else pass++;
      end
      chk++; if ({ifa.x_o, ifa.y_o, ifa.req_o} !== {xc, yc, xc < 640 && yc < 480}) $display("FAIL align_xy got %0d,%0d,%b want %0d,%0d", ifa.x_o, ifa.y_o, ifa.req_o, xc, yc); else pass++;
      if (p == 5 * 800 + 37) begin
        chk++; if ({r_a, g_a, b_a} !== 12'h552) $display("FAIL align_37_5 got %h want 552", {r_a, g_a, b_a}); else pass++;
      end
    end
  endtask
  task automatic test_blanking();
    int ts, nblank = 0;
    src_f = 1'b1; ts = cyc - t0;
    while (cyc - t0 < 5000) begin
      @(negedge clk);
      if (!de_a) begin
        nblank++;
        chk++; if ({r_a, g_a, b_a} !== 12'h000) $display("FAIL blank_zero t=%0d got %h want 000", cyc - t0, {r_a, g_a, b_a}); else pass++;
      end else if (cyc - t0 >= ts + 2) begin
        chk++; if ({r_a, g_a, b_a} !== 12'hFFF) $display("FAIL blank_active t=%0d got %h want fff", cyc - t0, {r_a, g_a, b_a}); else pass++;
      end
    end
    chk++; if (nblank !== 160) $display("FAIL blank_cycles got %0d want 160", nblank); else pass++;
  endtask
  task automatic test_vertical();
    int tt, q, hx, vy, vr1 = -1, vr2 = -1, vf = -1, fr1 = -1, fr2 = -1, des = 0;
    logic ehs, evs, ede, efr;
    logic pv = vs_c, pd = de_c;
    repeat (300) begin
      @(negedge clk);
      tt = cyc - t0;
      q = (tt - 2) % 128; hx = q % 16; vy = q / 16;
      ehs = hx >= 10 && hx < 13; evs = vy >= 5 && vy < 7; ede = hx < 8 && vy < 4; efr = q == 0;
      chk++; if ({hs_c, vs_c, de_c, fr_c} !== {ehs, evs, ede, efr}) $display("FAIL v_flags t=%0d got %b want %b", tt, {hs_c, vs_c, de_c, fr_c}, {ehs, evs, ede, efr}); else pass++;
      chk++; if ({r_c, g_c, b_c} !== (ede ? 12'hA53 : 12'h000)) $display("FAIL v_colour t=%0d got %h", tt, {r_c, g_c, b_c}); else pass++;
      if (!pv && vs_c) begin
        if (vr1 < 0) vr1 = tt;
        else if (vr2 < 0) vr2 = tt;
      end
      if (pv && !vs_c && vr1 >= 0 && vf < 0) vf = tt;
      if (fr_c) begin
        if (fr1 < 0) fr1 = tt;
        else if (fr2 < 0) fr2 = tt;
      end
      if (!pd && de_c && fr1 >= 0 && fr2 < 0) des++;
      pv = vs_c;
      pd = de_c;
    end
    chk++; if (vf - vr1 !== 32) $display("FAIL v_sync_width got %0d want 32", vf - vr1); else pass++;
    chk++; if (vr2 - vr1 !== 128) $display("FAIL v_period got %0d want 128", vr2 - vr1); else pass++;
    chk++; if (fr2 - fr1 !== 128) $display("FAIL v_frame_period got %0d want 128", fr2 - fr1); else pass++;
    chk++; if (des !== 4) $display("FAIL v_de_lines got %0d want 4", des); else pass++;
  endtask
  task automatic test_clkdiv2();
    int f1 = -1, r1 = -1, f2 = -1, tt;
    logic ph = hs_b;
    for (int i = 0; i < 4000 && f2 < 0; i++) begin
      @(negedge clk);
      tt = cyc - t0;
      chk++; if (ifb.x_o !== 10'((tt / 2) % 800)) $display("FAIL div2_hold t=%0d got %0d want %0d", tt, ifb.x_o, (tt / 2) % 800); else pass++;
      if (ph && !hs_b) begin
        if (f1 < 0) f1 = tt;
        else f2 = tt;
      end
      if (!ph && hs_b && f1 >= 0 && r1 < 0) r1 = tt;
      ph = hs_b;
    end
    chk++; if (f1 < 0 || (f1 - 2) % 1600 != 1312) $display("FAIL div2_fall_phase got %0d want phase 1312", f1); else pass++;
    chk++; if (r1 - f1 !== 192) $display("FAIL div2_sync_width got %0d want 192", r1 - f1); else pass++;
    chk++; if (f2 - f1 !== 1600) $display("FAIL div2_period got %0d want 1600", f2 - f1); else pass++;
  endtask
  task automatic test_midline_reset();
    for (int i = 0; i < 2000 && ifb.x_o !== 10'd700; i++) @(negedge clk);
    chk++; if (ifb.x_o !== 10'd700) $display("FAIL mid_reach_700 got %0d want 700", ifb.x_o); else pass++;
    chk++; if ({hs_b, de_b} !== 2'b00) $display("FAIL mid_pre_sync got %b want 00", {hs_b, de_b}); else pass++;
    rst_b_n = 1'b0;
    #1;
    chk++; if ({hs_b, vs_b, de_b, fr_b, r_b, g_b, b_b} !== {4'b1100, 12'h000}) $display("FAIL mid_async got %b want 1100", {hs_b, vs_b, de_b, fr_b}); else pass++;
    chk++; if ({ifb.x_o, ifb.y_o} !== 20'd0) $display("FAIL mid_async_xy got %0d,%0d want 0,0", ifb.x_o, ifb.y_o); else pass++;
    repeat (3) @(negedge clk);
    chk++; if ({hs_b, de_b, fr_b} !== 3'b100) $display("FAIL mid_hold got %b want 100", {hs_b, de_b, fr_b}); else pass++;
    rst_b_n = 1'b1;
    @(negedge clk);
    chk++; if ({fr_b, de_b} !== 2'b00) $display("FAIL mid_t1 got %b want 00", {fr_b, de_b}); else pass++;
    @(negedge clk);
    chk++; if ({fr_b, de_b, hs_b} !== 3'b111) $display("FAIL mid_t2 got %b want 111", {fr_b, de_b, hs_b}); else pass++;
    @(negedge clk);
    chk++; if ({fr_b, de_b} !== 2'b01) $display("FAIL mid_t3 got %b want 01", {fr_b, de_b}); else pass++;
  endtask
  initial begin
    test_reset();
    test_first_frame();
    test_horizontal();
    test_alignment();
    test_blanking();
    test_vertical();
    test_clkdiv2();
    test_midline_reset();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
